pipeline_ctrl: RTL and testbench

Central sequencer for the 5-stage MIPS pipeline. It gates the PC and the pipeline-register write enables, inserts bubbles and flushes, and holds the whole pipeline while a multi-cycle data-memory access completes. It sits beside the datapath and drives the PC, IF_ID, ID_EX, EX_MEM and MEM_WB control pins. All outputs are combinational from state, counter and inputs.

---
 rtl/pipeline_ctrl_pkg.sv | 49 ++++
 rtl/pipeline_ctrl_hazard_detect.sv | 22 ++
 rtl/pipeline_ctrl.sv | 127 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM encoding, control-pin bundle
// and the two canonical control patterns (normal RUN rules and full freeze).
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN      = 2'b01,
    ST_MEM_WAIT = 2'b10
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         LAT_W    = 4;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic mem_wb_bubble;
    logic mem_start;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Load-use stall outranks a redirect; the branch re-resolves next cycle.
  function automatic ctrl_t run_ctrl(input logic lu, input logic redirect);
    ctrl_t c;
    c               = '0;
    c.pc_write      = ~lu;
    c.if_id_write   = ~lu;
    c.if_id_flush   = redirect & ~lu;
    c.id_ex_write   = 1'b1;
    c.id_ex_bubble  = lu;
    c.ex_mem_write  = 1'b1;
    c.mem_wb_bubble = 1'b0;
    c.mem_start     = 1'b0;
    return c;
  endfunction

  function automatic ctrl_t freeze_ctrl();
    ctrl_t c;
    c               = '0;
    c.mem_wb_bubble = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination is read by the
// instruction in ID. Purely combinational.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  output logic       lu_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (ex_rt_i == id_rs_i);
  assign rt_hit = id_uses_rt_i & (ex_rt_i == id_rt_i);
  // r0 is hardwired, so a load targeting it never creates a dependency.
  assign lu_o   = ex_memread_i & (ex_rt_i != REG_ZERO) & (rs_hit | rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central 5-stage pipeline sequencer: PC/pipeline-register enables, bubbles,
// flushes and a whole-pipeline freeze across multi-cycle data-memory accesses.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             id_branch_taken_i,
  input  logic             id_jump_i,
  input  logic             mem_req_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_write_o,
  output logic             id_ex_bubble_o,
  output logic             ex_mem_write_o,
  output logic             mem_wb_bubble_o,
  output logic             mem_start_o,
  output logic             running_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [LAT_W-1:0] LAT_LAST    = LAT_W'(MEM_LAT - 1);
  localparam bit               MULTI_CYCLE = (MEM_LAT > 1);

  state_e           state_q, state_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic  lu;
  logic  redirect;
  logic  running;
  ctrl_t ctrl;

  hazard_detect u_hazard_detect (
    .ex_memread_i (ex_memread_i),
    .ex_rt_i      (ex_rt_i),
    .id_rs_i      (id_rs_i),
    .id_rt_i      (id_rt_i),
    .id_uses_rt_i (id_uses_rt_i),
    .lu_o         (lu)
  );

  assign redirect = id_branch_taken_i | id_jump_i;
  assign running  = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    ctrl      = CTRL_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (mem_req_i && MULTI_CYCLE) begin
          // Freeze starts on the issue cycle itself; lat_cnt counts it as 1.
          ctrl           = freeze_ctrl();
          ctrl.mem_start = 1'b1;
          lat_cnt_d      = LAT_W'(1);
          state_d        = ST_MEM_WAIT;
        end else begin
          ctrl           = run_ctrl(lu, redirect);
          ctrl.mem_start = mem_req_i;
          state_d        = start_i ? ST_RUN : ST_IDLE;
        end
      end
      ST_MEM_WAIT: begin
        if (lat_cnt_q < LAT_LAST) begin
          ctrl      = freeze_ctrl();
          lat_cnt_d = lat_cnt_q + 1'b1;
        end else begin
          // Release cycle: normal hazard rules apply, no new access can start.
          ctrl      = run_ctrl(lu, redirect);
          lat_cnt_d = '0;
          state_d   = start_i ? ST_RUN : ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        lat_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (running && !ctrl.pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      lat_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_write_o      = ctrl.pc_write;
  assign if_id_write_o   = ctrl.if_id_write;
  assign if_id_flush_o   = ctrl.if_id_flush;
  assign id_ex_write_o   = ctrl.id_ex_write;
  assign id_ex_bubble_o  = ctrl.id_ex_bubble;
  assign ex_mem_write_o  = ctrl.ex_mem_write;
  assign mem_wb_bubble_o = ctrl.mem_wb_bubble;
  assign mem_start_o     = ctrl.mem_start;
  assign running_o       = running;
  assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (MEM_LAT=4/CNT_W=16 and MEM_LAT=1/CNT_W=4)
// share stimulus; a cycle-level reference model feeds per-instance scoreboards.
module tb_pipeline_ctrl;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       rst_i, start_i, id_uses_rt_i, ex_memread_i;
  logic [4:0] id_rs_i, id_rt_i, ex_rt_i;
  logic       id_branch_taken_i, id_jump_i, mem_req_i;

  logic        pcw_a, ifw_a, fl_a, idw_a, idb_a, exw_a, wbb_a, ms_a, run_a;
  logic [15:0] cnt_a;
  logic        pcw_b, ifw_b, fl_b, idw_b, idb_b, exw_b, wbb_b, ms_b, run_b;
  logic [3:0]  cnt_b;

  pipeline_ctrl #(.MEM_LAT(4), .CNT_W(16)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i),
    .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i),
    .id_branch_taken_i(id_branch_taken_i), .id_jump_i(id_jump_i), .mem_req_i(mem_req_i),
    .pc_write_o(pcw_a), .if_id_write_o(ifw_a), .if_id_flush_o(fl_a),
    .id_ex_write_o(idw_a), .id_ex_bubble_o(idb_a), .ex_mem_write_o(exw_a),
    .mem_wb_bubble_o(wbb_a), .mem_start_o(ms_a), .running_o(run_a), .stall_cnt_o(cnt_a)
  );

  pipeline_ctrl #(.MEM_LAT(1), .CNT_W(4)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i),
    .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i),
    .id_branch_taken_i(id_branch_taken_i), .id_jump_i(id_jump_i), .mem_req_i(mem_req_i),
    .pc_write_o(pcw_b), .if_id_write_o(ifw_b), .if_id_flush_o(fl_b),
    .id_ex_write_o(idw_b), .id_ex_bubble_o(idb_b), .ex_mem_write_o(exw_b),
    .mem_wb_bubble_o(wbb_b), .mem_start_o(ms_b), .running_o(run_b), .stall_cnt_o(cnt_b)
  );

  // ctl = {pc_write, if_id_write, flush, id_ex_write, id_ex_bubble, ex_mem_write, mem_wb_bubble, mem_start, running}
  typedef struct packed {
    logic [8:0]  ctl;
    logic [15:0] cnt;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  // Reference model: "active" pipeline, optionally waiting for memory with a
  // countdown of cycles remaining until the access completes.
  int LAT[2]  = '{4, 1};
  int CMAX[2] = '{65535, 15};
  bit m_run[2], m_wait[2], nx_run[2], nx_wait[2];
  int m_rel[2], m_cnt[2], nx_rel[2], nx_cnt[2];

  function automatic exp_t act_a();
    return '{ctl: {pcw_a, ifw_a, fl_a, idw_a, idb_a, exw_a, wbb_a, ms_a, run_a}, cnt: cnt_a};
  endfunction

  function automatic exp_t act_b();
    return '{ctl: {pcw_b, ifw_b, fl_b, idw_b, idb_b, exw_b, wbb_b, ms_b, run_b}, cnt: {12'd0, cnt_b}};
  endfunction

  task automatic check(input string name, input exp_t got, input exp_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
               name, $time, got.ctl, got.cnt, exp.ctl, exp.cnt);
    end
  endtask

  always @(negedge clk_i) begin
    if (q_a.size() > 0) check("dut_a outputs", act_a(), q_a.pop_front());
    if (q_b.size() > 0) check("dut_b outputs", act_b(), q_b.pop_front());
  end

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_wait[k] = 0; m_rel[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_eval(input int k, output exp_t e);
    bit lu, redir, frozen, done, ms;
    bit pw, ifw, fl, idw, idb, exw, wbb;
    lu = ex_memread_i && (ex_rt_i != 0) &&
         ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
    redir = id_branch_taken_i || id_jump_i;
    e = '0;
    nx_run[k] = m_run[k]; nx_wait[k] = m_wait[k]; nx_rel[k] = m_rel[k]; nx_cnt[k] = m_cnt[k];
    if (!m_run[k] && !m_wait[k]) begin
      nx_run[k] = start_i;
    end else begin
      frozen = 0; done = 0; ms = 0;
      if (m_wait[k]) begin
        nx_rel[k] = m_rel[k] - 1;
        if (nx_rel[k] > 0) frozen = 1; else done = 1;
      end else if (mem_req_i) begin
        ms = 1;
        if (LAT[k] > 1) begin frozen = 1; nx_rel[k] = LAT[k] - 1; end
      end
      if (frozen) begin
        pw = 0; ifw = 0; fl = 0; idw = 0; idb = 0; exw = 0; wbb = 1;
      end else begin
        pw = !lu; ifw = !lu; fl = redir && !lu; idw = 1; idb = lu; exw = 1; wbb = 0;
      end
      if (m_wait[k]) begin
        if (done) begin nx_wait[k] = 0; nx_run[k] = start_i; end
      end else if (frozen) begin
        nx_wait[k] = 1; nx_run[k] = 0;
      end else begin
        nx_run[k] = start_i;
      end
      if (!pw && m_cnt[k] < CMAX[k]) nx_cnt[k] = m_cnt[k] + 1;
      e.ctl = {pw, ifw, fl, idw, idb, exw, wbb, ms, 1'b1};
    end
    e.cnt = 16'(m_cnt[k]);
  endtask

  task automatic step(input bit st, input int rs, input int rt, input bit ur,
                      input bit mr, input int ert, input bit br, input bit jp, input bit mq);
    exp_t ea, eb;
    start_i = st; id_rs_i = 5'(rs); id_rt_i = 5'(rt); id_uses_rt_i = ur;
    ex_memread_i = mr; ex_rt_i = 5'(ert); id_branch_taken_i = br; id_jump_i = jp; mem_req_i = mq;
    #0;
    model_eval(0, ea);
    model_eval(1, eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
    @(posedge clk_i);
    for (int k = 0; k < 2; k++) begin
      m_run[k] = nx_run[k]; m_wait[k] = nx_wait[k]; m_rel[k] = nx_rel[k]; m_cnt[k] = nx_cnt[k];
    end
    #1;
  endtask

  task automatic idle_step(input bit st);
    step(st, 1, 2, 0, 0, 0, 0, 0, 0);
  endtask

  int   cnt_before;
  exp_t zero_e;
  int   regs[4] = '{0, 8, 9, 3};

  initial begin
    zero_e = '0;
    rst_i = 1'b0; start_i = 0; id_rs_i = 0; id_rt_i = 0; id_uses_rt_i = 0;
    ex_memread_i = 0; ex_rt_i = 0; id_branch_taken_i = 0; id_jump_i = 0; mem_req_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    check("reset_a", act_a(), zero_e);
    check("reset_b", act_b(), zero_e);

    // Start one cycle after reset release, then plain RUN.
    idle_step(0);
    idle_step(1);
    idle_step(1);

    // Load-use on rs, then no stall when the load targets r0.
    step(1, 8, 2, 0, 1, 8, 0, 0, 0);
    idle_step(1);
    step(1, 0, 2, 0, 1, 0, 0, 0, 0);

    // Load-use on rt with a taken branch, then the branch re-resolves.
    step(1, 1, 9, 1, 1, 9, 1, 0, 0);
    step(1, 1, 9, 1, 0, 0, 1, 0, 0);

    // Memory access: dut_a freezes T..T+2, dut_b only pulses.
    cnt_before = int'(cnt_a);
    step(1, 1, 2, 0, 0, 0, 0, 0, 1);
    repeat (3) idle_step(1);
    check("mem_freeze_cnt", '{ctl: 9'd0, cnt: cnt_a}, '{ctl: 9'd0, cnt: 16'(cnt_before + 3)});

    // Drop start during the wait: access completes, then IDLE.
    step(1, 1, 2, 0, 0, 0, 0, 0, 1);
    repeat (3) idle_step(0);
    idle_step(0);
    idle_step(1);

    // Second access, async reset mid-freeze.
    step(1, 1, 2, 0, 0, 0, 0, 0, 1);
    idle_step(1);
    start_i = 0; mem_req_i = 0;
    #2 rst_i = 1'b0;
    #1;
    check("async_reset_a", act_a(), zero_e);
    check("async_reset_b", act_b(), zero_e);
    model_reset();
    @(negedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Continuous load-use: dut_b's 4-bit counter saturates at 15.
    idle_step(1);
    repeat (20) step(1, 8, 2, 0, 1, 8, 0, 0, 0);
    check("sat_b", '{ctl: 9'd0, cnt: {12'd0, cnt_b}}, '{ctl: 9'd0, cnt: 16'd15});
    check("count_a", '{ctl: 9'd0, cnt: cnt_a}, '{ctl: 9'd0, cnt: 16'd20});

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 16) != 0,
           regs[$urandom % 4], regs[$urandom % 4], $urandom % 2,
           $urandom % 2, regs[$urandom % 4],
           ($urandom % 5) == 0, ($urandom % 10) == 0, ($urandom % 7) == 0);
    end

    @(negedge clk_i);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
